// File: rtl/osnt_tx_queue.sv
// osnt_tx_queue: store-and-forward TX packet queue from the 512b AXI-S core egress to the 100G MAC TX, with oversize truncation and an optional departure stamp.
// Latency: a packet whose last beat is written in cycle N is counted at N+1 and offered (m_tvalid) at N+1 when the reader is idle; data is read combinationally.
// Backpressure: s_tready is low while the buffer is full (a same-cycle read frees space only from the next cycle); m_tvalid never gaps inside a packet.
// Ports: s_* core-side AXI-S sink; m_* MAC-side AXI-S source; ts_en/stamp_counter overwrite the stamp field of each first beat;
//        tx_pkt_sent/tx_pkt_trunc are one-cycle statistics pulses; pkt_count is the number of complete packets buffered.
module osnt_tx_queue #(
   parameter int AXI_DATA_WIDTH  = 512,
   parameter int AXI_USER_WIDTH  = 128,
   parameter int TXQUEUE_DEPTH   = 256,
   parameter int MAX_PKT_BEATS   = 160,
   parameter int TIMESTAMP_WIDTH = 64,
   parameter int TIMESTAMP_POS   = 176
) (
   input  logic                                 clk,
   input  logic                                 aresetn,
   input  logic [AXI_DATA_WIDTH-1:0]            s_tdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]          s_tkeep,
   input  logic [AXI_USER_WIDTH-1:0]            s_tuser,
   input  logic                                 s_tvalid,
   input  logic                                 s_tlast,
   output logic                                 s_tready,
   output logic [AXI_DATA_WIDTH-1:0]            m_tdata,
   output logic [AXI_DATA_WIDTH/8-1:0]          m_tkeep,
   output logic [AXI_USER_WIDTH-1:0]            m_tuser,
   output logic                                 m_tvalid,
   output logic                                 m_tlast,
   input  logic                                 m_tready,
   input  logic                                 ts_en,
   input  logic [TIMESTAMP_WIDTH-1:0]           stamp_counter,
   output logic                                 tx_pkt_sent,
   output logic                                 tx_pkt_trunc,
   output logic [$clog2(TXQUEUE_DEPTH):0]       pkt_count
);

   localparam int KEEP_W = AXI_DATA_WIDTH / 8;
   localparam int PTR_W  = $clog2(TXQUEUE_DEPTH);
   localparam int CNT_W  = $clog2(MAX_PKT_BEATS + 1);

   typedef struct packed {
      logic                      last;
      logic [KEEP_W-1:0]         keep;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [AXI_USER_WIDTH-1:0] user;
   } q_word_t;

   typedef enum logic {WR_ACCEPT, WR_DISCARD} wr_state_e;
   typedef enum logic {RD_IDLE, RD_SEND} rd_state_e;

   q_word_t            mem_q [TXQUEUE_DEPTH];

   wr_state_e          wr_state_q, wr_state_d;
   rd_state_e          rd_state_q, rd_state_d;
   logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [PTR_W:0]     pkt_count_q, pkt_count_d;
   logic               in_en_q, in_en_d;
   logic               sent_q, sent_d;
   logic               trunc_q, trunc_d;

   logic               full;
   logic               wr_en;
   logic               pkt_inc;
   logic               pkt_dec;
   q_word_t            wr_word;
   q_word_t            rd_word;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign full = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   // Write side: accept beats, truncate oversize packets, then swallow their tail.
   always_comb begin
      wr_state_d   = wr_state_q;
      wr_ptr_d     = wr_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      trunc_d      = 1'b0;
      wr_en        = 1'b0;
      pkt_inc      = 1'b0;
      s_tready     = 1'b0;
      wr_word.last = s_tlast;
      wr_word.keep = s_tkeep;
      wr_word.data = s_tdata;
      wr_word.user = s_tuser;
      case (wr_state_q)
         WR_ACCEPT: begin
            s_tready = in_en_q && !full;
            if (s_tvalid && in_en_q && !full) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (s_tlast) begin
                  beat_cnt_d = '0;
                  pkt_inc    = 1'b1;
               end else if (beat_cnt_q == CNT_W'(MAX_PKT_BEATS - 1)) begin
                  // Close the stored packet here so the reader can release it.
                  wr_word.last = 1'b1;
                  pkt_inc      = 1'b1;
                  trunc_d      = 1'b1;
                  beat_cnt_d   = '0;
                  wr_state_d   = WR_DISCARD;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         WR_DISCARD: begin
            s_tready = in_en_q;
            if (s_tvalid && in_en_q && s_tlast) begin
               wr_state_d = WR_ACCEPT;
               beat_cnt_d = '0;
            end
         end
         default: wr_state_d = WR_ACCEPT;
      endcase
   end

   // Read side: a packet is only started once it is complete in the buffer.
   assign rd_word = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      rd_state_d = rd_state_q;
      rd_ptr_d   = rd_ptr_q;
      sent_d     = 1'b0;
      pkt_dec    = 1'b0;
      m_tvalid   = 1'b0;
      case (rd_state_q)
         RD_IDLE: m_tvalid = (pkt_count_q != '0);
         RD_SEND: m_tvalid = 1'b1;
         default: m_tvalid = 1'b0;
      endcase
      if (m_tvalid && m_tready) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         if (rd_word.last) begin
            pkt_dec    = 1'b1;
            sent_d     = 1'b1;
            rd_state_d = RD_IDLE;
         end else begin
            rd_state_d = RD_SEND;
         end
      end
   end

   // Stamp is live, so the MAC captures the time of the first-beat handshake.
   always_comb begin
      m_tdata = rd_word.data;
      if (ts_en && (rd_state_q == RD_IDLE)) begin
         m_tdata[TIMESTAMP_POS +: TIMESTAMP_WIDTH] = stamp_counter;
      end
   end

   assign m_tkeep = rd_word.keep;
   assign m_tuser = rd_word.user;
   assign m_tlast = rd_word.last;

   always_comb begin
      case ({pkt_inc, pkt_dec})
         2'b10:   pkt_count_d = pkt_count_q + 1'b1;
         2'b01:   pkt_count_d = pkt_count_q - 1'b1;
         default: pkt_count_d = pkt_count_q;
      endcase
      in_en_d = 1'b1;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state_q  <= WR_ACCEPT;
         rd_state_q  <= RD_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         pkt_count_q <= '0;
         in_en_q     <= 1'b0;
         sent_q      <= 1'b0;
         trunc_q     <= 1'b0;
      end else begin
         wr_state_q  <= wr_state_d;
         rd_state_q  <= rd_state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         pkt_count_q <= pkt_count_d;
         in_en_q     <= in_en_d;
         sent_q      <= sent_d;
         trunc_q     <= trunc_d;
      end
   end

   // Buffer contents need no reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_word;
      end
   end

   assign tx_pkt_sent  = sent_q;
   assign tx_pkt_trunc = trunc_q;
   assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_osnt_tx_queue.sv
// tb_osnt_tx_queue: randomized bench for osnt_tx_queue against a packet-level reference model.
// Latency: inputs change 1 time unit after each rising edge; outputs are checked on the falling edge.
// Backpressure: the source holds a beat until accepted; MAC ready is forced or randomized per phase.
module tb_osnt_tx_queue;

   localparam int DW    = 512;
   localparam int KW    = DW / 8;
   localparam int UW    = 128;
   localparam int DEPTH = 256;
   localparam int MAXB  = 160;
   localparam int TSW   = 64;
   localparam int TSP   = 176;
   localparam logic [TSW-1:0] FIXED_STAMP = 64'h1122334455667788;

   logic            clk = 1'b0;
   logic            aresetn = 1'b1;
   logic [DW-1:0]   s_tdata = '0;
   logic [KW-1:0]   s_tkeep = '0;
   logic [UW-1:0]   s_tuser = '0;
   logic            s_tvalid = 1'b0;
   logic            s_tlast = 1'b0;
   logic            s_tready;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic [UW-1:0]   m_tuser;
   logic            m_tvalid;
   logic            m_tlast;
   logic            m_tready = 1'b0;
   logic            ts_en = 1'b0;
   logic [TSW-1:0]  stamp_counter = '0;
   logic            tx_pkt_sent;
   logic            tx_pkt_trunc;
   logic [8:0]      pkt_count;

   always #5 clk = ~clk;

   osnt_tx_queue dut (
      .clk(clk), .aresetn(aresetn),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
      .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
      .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .ts_en(ts_en), .stamp_counter(stamp_counter),
      .tx_pkt_sent(tx_pkt_sent), .tx_pkt_trunc(tx_pkt_trunc),
      .pkt_count(pkt_count)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
      logic          first;
   } exp_t;

   beat_t in_q[$];
   exp_t  exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: beat occupancy, complete packets, position in input packet.
   int occ = 0;
   int mdl_pkts = 0;
   int in_beat_idx = 0;
   bit mid_pkt = 0;
   bit sent_exp = 0;
   bit trunc_exp = 0;
   bit last_in_hs = 0;
   int sent_cnt = 0;
   int trunc_cnt = 0;
   logic [TSW-1:0] last_stamp = '0;

   int rdy_mode = 0;
   bit vld_all = 1;
   bit ts_rand = 0;
   bit fixed_stamp = 0;

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic add_pkt(input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         for (int w = 0; w < DW/32; w++) b.d[w*32 +: 32] = $urandom;
         b.k = {$urandom, $urandom};
         b.u = {$urandom, $urandom, $urandom, $urandom};
         b.l = (i == len - 1);
         in_q.push_back(b);
      end
   endtask

   task automatic evaluate();
      bit disc, in_hs, out_hs, lo;
      int pinc, pdec;
      exp_t e;
      beat_t b;
      logic [DW-1:0] ed;
      disc = (in_beat_idx >= MAXB);
      check_val("s_tready", s_tready, disc || (occ < DEPTH));
      check_val("m_tvalid", m_tvalid, mid_pkt || (mdl_pkts != 0));
      check_val("pkt_count", pkt_count, mdl_pkts);
      check_val("tx_pkt_sent", tx_pkt_sent, sent_exp);
      check_val("tx_pkt_trunc", tx_pkt_trunc, trunc_exp);
      if (tx_pkt_sent) sent_cnt++;
      if (tx_pkt_trunc) trunc_cnt++;
      in_hs  = s_tvalid && s_tready;
      out_hs = m_tvalid && m_tready;
      sent_exp = 0;
      trunc_exp = 0;
      pinc = 0;
      pdec = 0;
      if (out_hs) begin
         check_val("out_beat_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            ed = e.d;
            if (e.first && ts_en) ed[TSP +: TSW] = stamp_counter;
            if (e.first) last_stamp = m_tdata[TSP +: TSW];
            check_val("m_tdata", m_tdata, ed);
            check_val("m_tkeep", m_tkeep, e.k);
            check_val("m_tuser", m_tuser, e.u);
            check_val("m_tlast", m_tlast, e.l);
            occ--;
            mid_pkt = !e.l;
            if (e.l) begin
               pdec = 1;
               sent_exp = 1;
            end
         end
      end
      if (in_hs) begin
         b = in_q.pop_front();
         if (in_beat_idx < MAXB) begin
            lo = b.l || (in_beat_idx == MAXB - 1);
            exp_q.push_back('{d: b.d, k: b.k, u: b.u, l: lo, first: (in_beat_idx == 0)});
            occ++;
            if (lo) pinc = 1;
            if (!b.l && (in_beat_idx == MAXB - 1)) trunc_exp = 1;
         end
         in_beat_idx = b.l ? 0 : in_beat_idx + 1;
      end
      mdl_pkts = mdl_pkts + pinc - pdec;
      last_in_hs = in_hs;
   endtask

   // One clock: drive just after the rising edge, check on the falling edge.
   task automatic cycle();
      if (!(s_tvalid && !last_in_hs)) begin
         s_tvalid = (in_q.size() != 0) && (vld_all || ($urandom_range(0, 3) != 0));
      end
      if (in_q.size() != 0) begin
         s_tdata = in_q[0].d;
         s_tkeep = in_q[0].k;
         s_tuser = in_q[0].u;
         s_tlast = in_q[0].l;
      end
      case (rdy_mode)
         0:       m_tready = 1'b0;
         1:       m_tready = 1'b1;
         default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
      if (ts_rand) ts_en = $urandom_range(0, 1) != 0;
      stamp_counter = fixed_stamp ? FIXED_STAMP : {$urandom, $urandom};
      @(negedge clk);
      evaluate();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (((in_q.size() != 0) || (exp_q.size() != 0)) && (n < budget)) begin
         cycle();
         n++;
      end
      check_val("drain_done", in_q.size() + exp_q.size(), 0);
      run_cycles(3);
   endtask

   task automatic do_reset();
      aresetn  = 1'b0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      #1;
      check_val("rst_m_tvalid", m_tvalid, 1'b0);
      check_val("rst_s_tready", s_tready, 1'b0);
      check_val("rst_tx_pkt_sent", tx_pkt_sent, 1'b0);
      check_val("rst_tx_pkt_trunc", tx_pkt_trunc, 1'b0);
      check_val("rst_pkt_count", pkt_count, 0);
      in_q.delete();
      exp_q.delete();
      occ = 0;
      mdl_pkts = 0;
      in_beat_idx = 0;
      mid_pkt = 0;
      sent_exp = 0;
      trunc_exp = 0;
      last_in_hs = 0;
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      @(negedge clk);
      check_val("rel_s_tready", s_tready, 1'b0);
      check_val("rel_pkt_count", pkt_count, 0);
      check_val("rel_m_tvalid", m_tvalid, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int s0, t0, len;
      #2;
      do_reset();

      // Single 4-beat packet, MAC always ready.
      rdy_mode = 1; vld_all = 1;
      s0 = sent_cnt;
      add_pkt(4);
      drain(200);
      check_val("p1_sent_once", sent_cnt - s0, 1);

      // Fixed departure stamp on the first beat.
      ts_en = 1'b1; fixed_stamp = 1;
      add_pkt(3);
      drain(200);
      check_val("p2_stamp", last_stamp, FIXED_STAMP);
      ts_en = 1'b0; fixed_stamp = 0;

      // Fill the buffer with the MAC stalled, then release.
      rdy_mode = 0; vld_all = 1;
      for (int i = 0; i < 38; i++) add_pkt(8);
      run_cycles(300);
      check_val("full_pkt_count", pkt_count, 32);
      check_val("full_s_tready", s_tready, 1'b0);
      rdy_mode = 1;
      drain(2000);

      // Oversize packet followed by a normal one.
      t0 = trunc_cnt;
      add_pkt(170);
      add_pkt(5);
      rdy_mode = 2; vld_all = 0;
      drain(3000);
      check_val("p4_trunc_once", trunc_cnt - t0, 1);

      // Input and output tlast in the same cycle with two packets queued.
      rdy_mode = 0; vld_all = 1;
      add_pkt(1);
      add_pkt(1);
      run_cycles(5);
      check_val("p5_pre_count", pkt_count, 2);
      add_pkt(1);
      rdy_mode = 1;
      run_cycles(1);
      rdy_mode = 0;
      run_cycles(1);
      check_val("p5_same_cycle_count", pkt_count, 2);
      rdy_mode = 1;
      drain(200);

      // Reset in the middle of sending a packet.
      rdy_mode = 0; vld_all = 1;
      add_pkt(6);
      add_pkt(5);
      run_cycles(8);
      rdy_mode = 1;
      run_cycles(2);
      do_reset();
      s0 = sent_cnt;
      add_pkt(4);
      rdy_mode = 1;
      drain(200);
      check_val("p6_sent_after_reset", sent_cnt - s0, 1);

      // Randomized traffic, occasional oversize packets, random stamping.
      ts_rand = 1; rdy_mode = 2; vld_all = 0;
      for (int i = 0; i < 120; i++) begin
         len = ($urandom_range(0, 24) == 0) ? $urandom_range(161, 175) : $urandom_range(1, 12);
         add_pkt(len);
      end
      drain(20000);
      ts_rand = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/osnt_tx_queue.md
Name: osnt_tx_queue

Overview:
- Transmit-side packet queue between the core's 512-bit AXI-Stream egress and the 100G MAC TX interface, in a single clock domain.
- Store-and-forward operation: a packet is released to the MAC only once its last beat is buffered, so the MAC never sees a mid-packet valid gap.
- Optionally overwrites a departure timestamp into the first beat of each packet.
- Truncates oversize packets; reports sent and truncated events for statistics.

Parameters:
- AXI_DATA_WIDTH, 512, tdata width; tkeep width is AXI_DATA_WIDTH/8.
- AXI_USER_WIDTH, 128, tuser width.
- TXQUEUE_DEPTH, 256, buffer depth in beats; must be a power of two and >= MAX_PKT_BEATS.
- MAX_PKT_BEATS, 160, maximum stored beats per packet.
- TIMESTAMP_WIDTH, 64, stamp field width.
- TIMESTAMP_POS, 176, bit offset of the stamp field within beat 0.

Ports:
- clk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- s_tdata  in  AXI_DATA_WIDTH  core-side data.
- s_tkeep  in  AXI_DATA_WIDTH/8  byte enables.
- s_tuser  in  AXI_USER_WIDTH  sideband.
- s_tvalid  in  1  input valid.
- s_tlast  in  1  input end of packet.
- s_tready  out  1  input ready.
- m_tdata  out  AXI_DATA_WIDTH  MAC-side data.
- m_tkeep  out  AXI_DATA_WIDTH/8  byte enables.
- m_tuser  out  AXI_USER_WIDTH  sideband.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output end of packet.
- m_tready  in  1  MAC ready.
- ts_en  in  1  enables departure timestamp insertion.
- stamp_counter  in  TIMESTAMP_WIDTH  free-running time.
- tx_pkt_sent  out  1  one-cycle pulse when an output tlast handshake completes.
- tx_pkt_trunc  out  1  one-cycle pulse when a packet is truncated.
- pkt_count  out  log2(TXQUEUE_DEPTH)+1  number of complete packets buffered.

Behaviour:
- Reset (aresetn low, asynchronous):
  - Clears wr_ptr, rd_ptr, pkt_count, the beat counter and both state machines.
  - Forces s_tready=0, m_tvalid=0, tx_pkt_sent=0, tx_pkt_trunc=0.
  - FIFO contents are discarded. A packet partly sent at reset is abandoned without tlast; the MAC is reset alongside.
  - After reset release: s_tready=1 from the next cycle.
- Storage:
  - Array of {tlast, tkeep, tdata, tuser} words.
  - wr_ptr and rd_ptr carry one extra wrap bit.
  - full when the low bits are equal and the wrap bits differ; empty when both are equal.
  - Read is asynchronous, so m_* reflect the entry at rd_ptr combinationally.
- Write FSM, states ACCEPT and DISCARD:
  - ACCEPT: s_tready = !full.
    - Each handshake writes one beat and increments the beat counter.
    - s_tlast resets the counter and increments pkt_count.
    - If the counter is MAX_PKT_BEATS-1 and s_tlast=0: the beat is written with tlast forced to 1 and pkt_count increments. tx_pkt_trunc pulses in the following cycle. FSM goes to DISCARD.
  - DISCARD: s_tready=1; beats are consumed but not written. The s_tlast handshake returns the FSM to ACCEPT and clears the counter.
- Read FSM, states IDLE and SEND:
  - IDLE: m_tvalid = (pkt_count != 0). A handshake moves to SEND, or stays in IDLE if m_tlast.
  - SEND: m_tvalid = 1; the complete packet is guaranteed resident, so valid never drops mid-packet.
  - Every handshake increments rd_ptr. The tlast handshake decrements pkt_count, pulses tx_pkt_sent in the following cycle, and returns to IDLE.
  - m_tvalid, once high, holds with stable data until m_tready (AXI rule).
- Latency:
  - The last beat written in cycle N makes pkt_count increment at N+1; m_tvalid rises at N+1 if the queue was idle.
  - Same-cycle increment (input tlast) and decrement (output tlast) leave pkt_count unchanged.
- Timestamp insertion:
  - Applies only when ts_en=1 and the read FSM is in IDLE.
  - m_tdata[TIMESTAMP_POS+TIMESTAMP_WIDTH-1:TIMESTAMP_POS] = stamp_counter (live value); all other bits pass through.
  - Because the value is live, the stamp captured by the MAC is stamp_counter at the first-beat handshake cycle.
  - Other beats, and all beats when ts_en=0, pass through unmodified.
- Deadlock freedom: a partial packet can never fill the buffer, because truncation occurs at MAX_PKT_BEATS <= TXQUEUE_DEPTH.
- Full: with ACCEPT active and the buffer full, s_tready=0. A simultaneous read frees space only from the next cycle; there is no same-cycle pass-through.

Test Plan:
- Reset, then one 4-beat packet, m_tready=1 -> m_tvalid rises 1 cycle after input tlast; beats appear in order; tx_pkt_sent pulses once; pkt_count returns to 0.
- ts_en=1, stamp_counter=0x1122334455667788 at the first output handshake -> bits [239:176] of beat 0 equal that value; beats 1..n are unmodified.
- m_tready held 0 while 300 beats of 8-beat packets are offered -> s_tready falls after 256 beats; after releasing m_tready, all 32 packets are output intact with no valid gaps inside any packet.
- 170-beat packet with s_tlast only on beat 170 -> 160 beats stored with tlast on beat 160; tx_pkt_trunc pulses once; the next packet is stored normally.
- Input tlast and output tlast in the same cycle with pkt_count=2 -> pkt_count stays 2.
- aresetn asserted mid-SEND -> m_tvalid=0 and s_tready=0 immediately; after release, pkt_count=0 and a new packet is sent cleanly.
